// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//   Single-clock FIFO with registered read data and pointer-decoded status.
//   Words written on w_en are returned in order on r_en; d_out updates one
//   cycle after an accepted read and otherwise holds its value.
//
// Parameters
//   DATA_WIDTH  width of each stored word
//   DEPTH       number of entries (power of two, >= 2)
//
// Ports
//   clk        sole clock, rising edge
//   resetn     asynchronous active-low reset
//   w_en       write request (accepted when !full)
//   r_en       read request (accepted when !empty)
//   d_in       write data
//   d_out      registered read data
//   full       count == DEPTH
//   empty      count == 0
//   count      number of stored words
//   overflow   sticky: write attempted while full    (SYNC_FIFO_ERR_EN only)
//   underflow  sticky: read attempted while empty    (SYNC_FIFO_ERR_EN only)
//
// Build option
//   SYNC_FIFO_ERR_EN  adds the overflow/underflow ports and their logic.
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       w_en,
    input  logic                       r_en,
    input  logic [DATA_WIDTH-1:0]      d_in,
    output logic [DATA_WIDTH-1:0]      d_out,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
`ifdef SYNC_FIFO_ERR_EN
    ,
    output logic                       overflow,
    output logic                       underflow
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW:0]           wptr;
    logic [AW:0]           rptr;
    logic                  w_acc;
    logic                  r_acc;

    // Status is decoded from registered pointers only; the extra MSB
    // distinguishes full (wrapped once more) from empty (identical).
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
    assign count = wptr - rptr;

    assign w_acc = w_en && !full;
    assign r_acc = r_en && !empty;

    // Storage is not reset; stale contents are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (w_acc)
            mem[wptr[AW-1:0]] <= d_in;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr  <= '0;
            rptr  <= '0;
            d_out <= '0;
        end else begin
            if (w_acc)
                wptr <= wptr + PTR_ONE;
            if (r_acc) begin
                d_out <= mem[rptr[AW-1:0]];
                rptr  <= rptr + PTR_ONE;
            end
        end
    end

`ifdef SYNC_FIFO_ERR_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (w_en && full)
                overflow <= 1'b1;
            if (r_en && empty)
                underflow <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo
//   Randomized and directed stimulus for sync_fifo, checked against a
//   queue-based reference model. Outputs are sampled 1ns after each rising
//   edge; inputs change at the same point, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_sync_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int AW    = $clog2(DEPTH);

    logic          clk;
    logic          resetn;
    logic          w_en;
    logic          r_en;
    logic [DW-1:0] d_in;
    logic [DW-1:0] d_out;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
`ifdef SYNC_FIFO_ERR_EN
    logic          overflow;
    logic          underflow;
`endif

    sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .w_en     (w_en),
        .r_en     (r_en),
        .d_in     (d_in),
        .d_out    (d_out),
        .full     (full),
        .empty    (empty),
        .count    (count)
`ifdef SYNC_FIFO_ERR_EN
        ,
        .overflow (overflow),
        .underflow(underflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model
    logic [DW-1:0] q [$];
    logic [DW-1:0] exp_dout;
    logic          exp_ovf;
    logic          exp_udf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, ".count"}, 32'(count), 32'(q.size()));
        chk({tag, ".full"},  32'(full),  32'(q.size() == DEPTH));
        chk({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
        chk({tag, ".dout"},  32'(d_out), 32'(exp_dout));
`ifdef SYNC_FIFO_ERR_EN
        chk({tag, ".ovf"},   32'(overflow),  32'(exp_ovf));
        chk({tag, ".udf"},   32'(underflow), 32'(exp_udf));
`endif
    endtask

    task automatic model_reset();
        q.delete();
        exp_dout = '0;
        exp_ovf  = 1'b0;
        exp_udf  = 1'b0;
    endtask

    // One clock with the given request; model advances from pre-edge state.
    task automatic cyc(input logic w, input logic r, input logic [DW-1:0] d, input string tag);
        int sz;
        w_en = w;
        r_en = r;
        d_in = d;
        @(posedge clk);
        sz = q.size();
        if (w && sz == DEPTH) exp_ovf = 1'b1;
        if (r && sz == 0)     exp_udf = 1'b1;
        if (r && sz > 0)      exp_dout = q.pop_front();
        if (w && sz < DEPTH)  q.push_back(d);
        #1;
        w_en = 1'b0;
        r_en = 1'b0;
        chk_state(tag);
    endtask

    initial begin
        resetn = 1'b0;
        w_en   = 1'b0;
        r_en   = 1'b0;
        d_in   = '0;
        model_reset();
        #2;
        chk_state("reset");
        @(posedge clk);
        #1 resetn = 1'b1;

        // reset mid-operation with 3 words stored and d_out non-zero
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, DW'(8'h51 + i), "pre_rst_wr");
        cyc(1'b0, 1'b1, '0, "pre_rst_rd");
        chk("pre_rst_count", 32'(count), 32'd3);
        #2 resetn = 1'b0;
        model_reset();
        #1;
        chk_state("async_rst");
        @(posedge clk);
        #1 resetn = 1'b1;

        // fill 0x01..0x08
        for (int i = 1; i <= DEPTH; i++) cyc(1'b1, 1'b0, DW'(i), "fill");
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_count", 32'(count), 32'd8);

        // overflow attempt
        cyc(1'b1, 1'b0, 8'hAA, "ovf");
`ifdef SYNC_FIFO_ERR_EN
        chk("ovf_flag", 32'(overflow), 32'd1);
`endif

        // drain, order must be 0x01..0x08
        for (int i = 1; i <= DEPTH; i++) begin
            cyc(1'b0, 1'b1, '0, "drain");
            chk("drain_order", 32'(d_out), 32'(i));
        end
        chk("drain_empty", 32'(empty), 32'd1);

        // underflow: d_out holds 0x08
        cyc(1'b0, 1'b1, '0, "udf");
        chk("udf_hold", 32'(d_out), 32'h08);
`ifdef SYNC_FIFO_ERR_EN
        chk("udf_flag", 32'(underflow), 32'd1);
`endif

        // empty + both: only the write lands, no bypass
        cyc(1'b1, 1'b1, 8'h3C, "empty_both");
        chk("empty_both_count", 32'(count), 32'd1);
        chk("empty_both_dout", 32'(d_out), 32'h08);

        // bring to 4 stored, then 20 cycles of simultaneous traffic
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, DW'(8'h40 + i), "to4");
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, DW'(8'h60 + i), "simul");
        chk("simul_count", 32'(count), 32'd4);

        // full + both: only the read lands
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, DW'(8'h90 + i), "to_full");
        chk("pre_fb_full", 32'(full), 32'd1);
        cyc(1'b1, 1'b1, 8'hEE, "full_both");
        chk("full_both_count", 32'(count), 32'd7);

        // randomized traffic
        for (int i = 0; i < 400; i++)
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), DW'($urandom), "rand");

        // drain whatever remains so order is verified to the end
        for (int i = 0; i < DEPTH + 1; i++) cyc(1'b0, 1'b1, '0, "final_drain");
        chk("final_empty", 32'(empty), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
